// File: rtl/default_hash_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// default_hash_unit_pkg : shared types, constants and LFSR re-key step
// Rev 1.0
// ----------------------------------------------------------------------------
package default_hash_unit_pkg;

  localparam int HASH_ADDR_WIDTH = 64;

  typedef logic [HASH_ADDR_WIDTH-1:0] addr_bits;

  localparam addr_bits LFSR_MASK   = 64'hD800000000000000;
  localparam addr_bits COE_A_RESET = 64'h9E3779B97F4A7C15;
  localparam addr_bits COE_B_RESET = 64'hC2B2AE3D27D4EB4F;

  // Galois step with LSB forced high so a coefficient can never become even.
  function automatic addr_bits lfsr_step(input addr_bits x);
    return ((x >> 1) ^ (x[0] ? LFSR_MASK : '0)) | addr_bits'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/default_hash_unit_coef_lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hash_coef_lfsr : one hash coefficient, re-keyed by an LFSR step on refresh
// Rev 1.0
// ----------------------------------------------------------------------------
module hash_coef_lfsr
  import default_hash_unit_pkg::*;
#(
  parameter int               WIDTH = HASH_ADDR_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(COE_A_RESET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  output logic [WIDTH-1:0] coef
);

  logic [WIDTH-1:0] coef_q;
  logic [WIDTH-1:0] coef_d;
  logic [WIDTH-1:0] step;

  generate
    if (WIDTH == HASH_ADDR_WIDTH) begin : g_pkg_step
      assign step = lfsr_step(coef_q);
    end else begin : g_narrow_step
      // Narrow coefficients keep the top taps of the full-width polynomial.
      localparam logic [WIDTH-1:0] c_narrow_mask = LFSR_MASK[HASH_ADDR_WIDTH-1 -: WIDTH];
      assign step = ((coef_q >> 1) ^ (coef_q[0] ? c_narrow_mask : '0)) | WIDTH'(1);
    end
  endgenerate

  always_comb begin
    coef_d = coef_q;
    if (refresh) begin
      coef_d = step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= INIT;
    end else begin
      coef_q <= coef_d;
    end
  end

  assign coef = coef_q;

endmodule
`default_nettype wire

// File: rtl/default_hash_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// default_hash_unit : pipelined two-coefficient multiplicative address hash
// Rev 1.0
// ----------------------------------------------------------------------------
module default_hash_unit
  import default_hash_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = HASH_ADDR_WIDTH,
  parameter int                    HASH_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] COE_A_INIT = ADDR_WIDTH'(COE_A_RESET),
  parameter logic [ADDR_WIDTH-1:0] COE_B_INIT = ADDR_WIDTH'(COE_B_RESET)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    refresh,
  output logic                    resp_valid,
  output logic [HASH_WIDTH-1:0]   resp_hash,
  output logic [ADDR_WIDTH-1:0]   coe_a,
  output logic [ADDR_WIDTH-1:0]   coe_b,
  output logic [ADDR_WIDTH-1:0]   dbg_sva,
  output logic [ADDR_WIDTH/2-1:0] dbg_upper,
  output logic [ADDR_WIDTH/2-1:0] dbg_lower
);

  localparam int HALF = ADDR_WIDTH / 2;

  hash_coef_lfsr #(
    .WIDTH (ADDR_WIDTH),
    .INIT  (COE_A_INIT)
  ) u_coef_a (
    .clk     (clk),
    .rst     (rst),
    .refresh (refresh),
    .coef    (coe_a)
  );

  hash_coef_lfsr #(
    .WIDTH (ADDR_WIDTH),
    .INIT  (COE_B_INIT)
  ) u_coef_b (
    .clk     (clk),
    .rst     (rst),
    .refresh (refresh),
    .coef    (coe_b)
  );

  // Stage 1: address capture plus coefficient snapshot
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] sva_q, sva_d;
  logic [HALF-1:0]       upper_q, upper_d;
  logic [HALF-1:0]       lower_q, lower_d;
  logic [ADDR_WIDTH-1:0] snap_a_q, snap_a_d;
  logic [ADDR_WIDTH-1:0] snap_b_q, snap_b_d;

  // Stage 2: truncated partial products
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] prod_a_q, prod_a_d;
  logic [ADDR_WIDTH-1:0] prod_b_q, prod_b_d;

  // Stage 3: summed result
  logic                  resp_valid_q, resp_valid_d;
  logic [HASH_WIDTH-1:0] resp_hash_q, resp_hash_d;
  logic [ADDR_WIDTH-1:0] sum;

  // The snapshot reads coe_a/coe_b before any same-cycle refresh lands.
  always_comb begin
    s1_valid_d = req_valid;
    sva_d      = sva_q;
    upper_d    = upper_q;
    lower_d    = lower_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    if (req_valid) begin
      sva_d    = req_addr;
      upper_d  = req_addr[ADDR_WIDTH-1:HALF];
      lower_d  = req_addr[HALF-1:0];
      snap_a_d = coe_a;
      snap_b_d = coe_b;
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    prod_a_d   = prod_a_q;
    prod_b_d   = prod_b_q;
    if (s1_valid_q) begin
      prod_a_d = snap_a_q * ADDR_WIDTH'(upper_q);
      prod_b_d = snap_b_q * ADDR_WIDTH'(lower_q);
    end
  end

  assign sum = prod_a_q + prod_b_q;

  always_comb begin
    resp_valid_d = s2_valid_q;
    resp_hash_d  = resp_hash_q;
    if (s2_valid_q) begin
      resp_hash_d = sum[ADDR_WIDTH-1 -: HASH_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      sva_q        <= '0;
      upper_q      <= '0;
      lower_q      <= '0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      s2_valid_q   <= 1'b0;
      prod_a_q     <= '0;
      prod_b_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hash_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      sva_q        <= sva_d;
      upper_q      <= upper_d;
      lower_q      <= lower_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      s2_valid_q   <= s2_valid_d;
      prod_a_q     <= prod_a_d;
      prod_b_q     <= prod_b_d;
      resp_valid_q <= resp_valid_d;
      resp_hash_q  <= resp_hash_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hash  = resp_hash_q;
  assign dbg_sva    = sva_q;
  assign dbg_upper  = upper_q;
  assign dbg_lower  = lower_q;

endmodule
`default_nettype wire

// File: tb/tb_default_hash_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_default_hash_unit : directed self-checking bench for default_hash_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_default_hash_unit;

  localparam logic [63:0] A0 = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] B0 = 64'hC2B2AE3D27D4EB4F;
  localparam logic [63:0] A1 = 64'h971BBCDCBFA53E0B;
  localparam logic [63:0] B1 = 64'hB959571E93EA75A7;
  localparam logic [63:0] A2 = 64'h938DDE6E5FD29F05;
  localparam logic [63:0] B2 = 64'h84ACAB8F49F53AD3;
  localparam logic [63:0] MIX = 64'hAAAAAAAABBBBBBBB;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        refresh;
  logic        resp_valid;
  logic [63:0] resp_hash;
  logic [63:0] coe_a;
  logic [63:0] coe_b;
  logic [63:0] dbg_sva;
  logic [31:0] dbg_upper;
  logic [31:0] dbg_lower;

  int n_cmp = 0;
  int n_mis = 0;

  default_hash_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .refresh    (refresh),
    .resp_valid (resp_valid),
    .resp_hash  (resp_hash),
    .coe_a      (coe_a),
    .coe_b      (coe_b),
    .dbg_sva    (dbg_sva),
    .dbg_upper  (dbg_upper),
    .dbg_lower  (dbg_lower)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] hash_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] addr);
    logic [63:0] hi;
    logic [63:0] lo;
    hi = {32'h0, addr[63:32]};
    lo = {32'h0, addr[31:0]};
    return a * hi + b * lo;
  endfunction

  function automatic logic [63:0] step_model(input logic [63:0] x);
    return ((x >> 1) ^ (x[0] ? 64'hD800000000000000 : 64'h0)) | 64'h1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request: drive, check capture, check latency and result.
  task automatic do_req(input string tag, input logic [63:0] addr, input logic [63:0] exp_hash);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_dbg_sva"}, dbg_sva, addr);
    check({tag, "_dbg_upper"}, {32'h0, dbg_upper}, {32'h0, addr[63:32]});
    check({tag, "_dbg_lower"}, {32'h0, dbg_lower}, {32'h0, addr[31:0]});
    @(negedge clk);
    check({tag, "_early_valid"}, {63'h0, resp_valid}, 64'h0);
    @(negedge clk);
    check({tag, "_valid"}, {63'h0, resp_valid}, 64'h1);
    check({tag, "_hash"}, resp_hash, exp_hash);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a3, b3, a4, b4, a5, b5, xaddr;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    refresh   = 1'b0;
    #3;
    check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("rst_resp_hash", resp_hash, 64'h0);
    check("rst_coe_a", coe_a, A0);
    check("rst_coe_b", coe_b, B0);
    check("rst_dbg_sva", dbg_sva, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req("zero", 64'h0, 64'h0);
    do_req("upper1", 64'h0000000100000000, A0);
    do_req("lower1", 64'h1, B0);
    do_req("mix0", MIX, hash_model(A0, B0, MIX));

    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    check("ref1_coe_a", coe_a, A1);
    check("ref1_coe_b", coe_b, B1);
    do_req("mix1", MIX, hash_model(A1, B1, MIX));

    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    check("ref2_coe_a", coe_a, A2);
    check("ref2_coe_b", coe_b, B2);
    do_req("mix2", MIX, hash_model(A2, B2, MIX));

    // Refresh coincident with a request, followed back-to-back by the same address.
    a3    = step_model(A2);
    b3    = step_model(B2);
    xaddr = 64'h0000000200000003;
    @(negedge clk);
    req_valid = 1'b1;
    refresh   = 1'b1;
    req_addr  = xaddr;
    @(negedge clk);
    refresh = 1'b0;
    check("coin_coe_a", coe_a, a3);
    check("coin_coe_b", coe_b, b3);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("coin_old_valid", {63'h0, resp_valid}, 64'h1);
    check("coin_old_hash", resp_hash, hash_model(A2, B2, xaddr));
    @(negedge clk);
    check("coin_new_valid", {63'h0, resp_valid}, 64'h1);
    check("coin_new_hash", resp_hash, hash_model(a3, b3, xaddr));
    @(negedge clk);
    check("bubble_valid", {63'h0, resp_valid}, 64'h0);
    check("bubble_hold", resp_hash, hash_model(a3, b3, xaddr));

    // Back-to-back refresh pulses step once per cycle.
    a4 = step_model(a3);
    b4 = step_model(b3);
    a5 = step_model(a4);
    b5 = step_model(b4);
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    check("b2b1_coe_a", coe_a, a4);
    check("b2b1_coe_b", coe_b, b4);
    @(negedge clk);
    refresh = 1'b0;
    check("b2b2_coe_a", coe_a, a5);
    check("b2b2_coe_b", coe_b, b5);

    // Reset with two requests in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h1;
    @(negedge clk);
    req_addr  = 64'h0000000100000000;
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check("mid_rst_valid", {63'h0, resp_valid}, 64'h0);
    check("mid_rst_hash", resp_hash, 64'h0);
    check("mid_rst_coe_a", coe_a, A0);
    check("mid_rst_coe_b", coe_b, B0);
    check("mid_rst_dbg_sva", dbg_sva, 64'h0);
    check("mid_rst_dbg_upper", {32'h0, dbg_upper}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {63'h0, resp_valid}, 64'h0);
    end

    do_req("post_rst", 64'h1, B0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
